fifo_umbrales: RTL
==================

Name: fifo_umbrales

Overview:
Synchronous FIFO that receives push/pop traffic and exposes occupancy status. Sits between the packet source and the downstream consumer. Flags are driven by two runtime-programmable thresholds: alto (almost-full) and bajo (almost-empty). Overflow and underflow are reported on a sticky error flag.

Parameters:
data_width, 10, width of each stored word
address_width, 3, pointer width; depth = 2**address_width (8 entries); also the width of alto/bajo

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
FIFO_data_in  input  data_width  write data, sampled when push accepted
push  input  1  write request
pop  input  1  read request
alto  input  address_width  almost-full threshold
bajo  input  address_width  almost-empty threshold
FIFO_data_out  output  data_width  registered read data
valid_out  output  1  high for one cycle when FIFO_data_out carries a newly popped word
full  output  1  count == depth
empty  output  1  count == 0
almost_full  output  1  count >= alto
almost_empty  output  1  count <= bajo
error  output  1  sticky overflow/underflow flag
fifo_count  output  address_width+1  current occupancy, 0..depth

Behaviour:
- Reset (reset == 0, asynchronous):
  - wr_ptr, rd_ptr, count = 0; FIFO_data_out = 0; valid_out = 0; error = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1 (since 0 <= bajo), almost_full = (alto == 0).
  - Memory contents need not be cleared.
- Reset mid-operation: all stored data is discarded and state returns to the reset values immediately, without waiting for a clock edge.
- Accept rules, evaluated on each rising edge:
  - wr_acc = push & (~full | pop)
  - rd_acc = pop & ~empty
- Write: on wr_acc, mem[wr_ptr] <= FIFO_data_in; wr_ptr increments and wraps modulo depth.
- Read:
  - On rd_acc, FIFO_data_out <= mem[rd_ptr] and rd_ptr increments with wrap. One-cycle latency: data and valid_out = 1 appear the edge after pop is sampled.
  - Without rd_acc, valid_out = 0 and FIFO_data_out holds its last value.
- Count update: count <= count + wr_acc - rd_acc.
- Simultaneous push and pop:
  - Not full, not empty: both happen, count unchanged.
  - Full: pop frees a slot, so the push is accepted; count stays at depth and no error is raised.
  - Empty: no bypass. The push is written, the pop is ignored, count becomes 1, and error is set (underflow).
- Overflow: push & full & ~pop sets error; the write is dropped and the pointers are unchanged.
- Underflow: pop & empty sets error; no pointer change, valid_out = 0.
- error stays high until reset.
- Flags full, empty, almost_full and almost_empty are combinational from the registered count, so they are glitch-free relative to clk.
- Thresholds:
  - alto and bajo are compared unsigned against count, zero-extended to address_width+1.
  - They may change at any time; the flags reflect new values in the same cycle.
  - alto = 0 forces almost_full = 1.
- Pointer wrap: write and read pointers wrap independently from depth-1 to 0. Full/empty status is taken only from count, never from pointer equality.

Test Plan:
- Reset then idle: reset low for 2 cycles, alto = 6, bajo = 1 -> count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, error = 0, valid_out = 0.
- Fill: push 8 words 0x090..0x097 on consecutive cycles -> count steps 1..8; almost_empty drops when count = 2; almost_full rises when count = 6; full = 1 after the 8th push; error = 0.
- Overflow plus drain:
  - With the FIFO full, push 0x098 alone -> error = 1, count stays 8.
  - Then pop 8 cycles -> FIFO_data_out = 0x090..0x097 in order, each one cycle after its pop, valid_out high 8 cycles; empty = 1 at end; 0x098 never appears.
- Full push+pop and wrap: fill 8, then push 0x0A0..0x0A3 with pop for 4 cycles -> outputs 0x090..0x093, count stays 8, error = 0. Then drain -> 0x094..0x097 followed by 0x0A0..0x0A3, confirming pointer wrap.
- Underflow on empty with simultaneous push: from empty, push 0x055 and pop in the same cycle -> count = 1, valid_out = 0, error = 1. Next pop -> FIFO_data_out = 0x055.
- Async reset mid-stream: with count = 5, assert reset between edges -> count = 0, empty = 1, error = 0 immediately, before the next edge. After release, push 0x011 and pop -> 0x011 is returned.

Source files
------------

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with sticky overflow/underflow error and two runtime-programmable
// occupancy thresholds (alto = almost-full, bajo = almost-empty).
module fifo_umbrales #(
  parameter int data_width    = 10,
  parameter int address_width = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [data_width-1:0]    FIFO_data_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [address_width-1:0] alto,
  input  logic [address_width-1:0] bajo,
  output logic [data_width-1:0]    FIFO_data_out,
  output logic                     valid_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     error,
  output logic [address_width:0]   fifo_count
);

  localparam int depth = 2 ** address_width;
  localparam logic [address_width:0] depth_cnt = {1'b1, {address_width{1'b0}}};

  logic [data_width-1:0]    mem [depth];
  logic [address_width-1:0] wr_ptr;
  logic [address_width-1:0] rd_ptr;
  logic [address_width:0]   count;
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     err_event;

  // Status comes only from the registered count, never from pointer equality.
  always_comb begin
    full         = (count == depth_cnt);
    empty        = (count == '0);
    almost_full  = (count >= {1'b0, alto});
    almost_empty = (count <= {1'b0, bajo});
    fifo_count   = count;
  end

  // A pop frees a slot when full, so push+pop on a full FIFO is accepted;
  // on empty there is no bypass and the pop is an underflow.
  always_comb begin
    wr_acc    = push & (~full | pop);
    rd_acc    = pop & ~empty;
    err_event = (push & full & ~pop) | (pop & empty);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= FIFO_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FIFO_data_out <= '0;
      valid_out     <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      if (rd_acc) begin
        FIFO_data_out <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if (err_event) begin
      error <= 1'b1;
    end
  end

endmodule
